// File: rtl/pc_gen_ras_pkg.sv
// pc_pkg: shared widths, defaults and next-PC source selector for the fetch PC generator
package pc_pkg;
   localparam int ADDR_W_DEF      = 16;
   localparam int INSTR_BYTES_DEF = 2;
   localparam int RAS_DEPTH_DEF   = 4;
   localparam int RAS_PTR_W       = $clog2(RAS_DEPTH_DEF);
   typedef enum logic [1:0] {SEL_HOLD, SEL_SEQ, SEL_RAS, SEL_REDIRECT} next_sel_e;
endpackage

// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if: fetch control inputs and PC/RAS status outputs of the fetch PC generator
//   master drives enable/redirect/call/ret; slave (the PC generator) drives pc_* and ras_* status
interface pc_gen_ras_if
   import pc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) ();
   logic              enable;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              call_valid;
   logic              ret_valid;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_nxt;
   logic              pc_valid;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_overflow;
   logic              ret_miss;
   modport master (
      output enable, redirect_valid, redirect_addr, call_valid, ret_valid,
      input  pc_out, pc_nxt, pc_valid, ras_empty, ras_full, ras_overflow, ret_miss
   );
   modport slave (
      input  enable, redirect_valid, redirect_addr, call_valid, ret_valid,
      output pc_out, pc_nxt, pc_valid, ras_empty, ras_full, ras_overflow, ret_miss
   );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// ras_stack: circular return-address stack with saturating count and sticky overflow
//   push/pop request, push_data in; top_data, empty, full, overflow out
//   pop+push together replaces the top entry; a push while full overwrites the oldest entry
module ras_stack
   import pc_pkg::*;
#(
   parameter int RAS_DEPTH = RAS_DEPTH_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top_data,
   output logic              empty,
   output logic              full,
   output logic              overflow
);
   localparam int PW = $clog2(RAS_DEPTH);
   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]     top;
   logic [PW:0]       count;
   logic              do_pop;
   logic              replace;
   assign do_pop   = pop & !empty;
   assign replace  = do_pop & push;
   assign empty    = count == '0;
   assign full     = count == (PW+1)'(RAS_DEPTH);
   assign top_data = mem[top];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         top      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push && !replace) begin
         top <= top + PW'(1);
         if (full) overflow <= 1'b1;
         else count <= count + (PW+1)'(1);
      end else if (do_pop && !replace) begin
         top   <= top - PW'(1);
         count <= count - (PW+1)'(1);
      end
   // entries are not reset; the write slot is the top itself on a replace
   always_ff @(posedge clk)
      if (push) mem[replace ? top : top + PW'(1)] <= push_data;
endmodule

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch PC register with redirect / return-prediction / sequential next-PC select
//   clk, reset_n (async, active low); bus (slave): fetch controls in, pc_out/pc_nxt/pc_valid
//   and RAS status out
module pc_gen_ras
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                INSTR_BYTES = INSTR_BYTES_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int                RAS_DEPTH   = RAS_DEPTH_DEF
) (
   input logic         clk,
   input logic         reset_n,
   pc_gen_ras_if.slave bus
);
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] ras_top;
   logic              pc_valid;
   logic              ret_miss;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_overflow;
   logic              accept;
   logic              push;
   logic              pop;
   next_sel_e         sel;
   assign pc_nxt = pc_q + ADDR_W'(INSTR_BYTES);
   // call/ret only act on an advancing, non-flushed cycle after the first valid edge
   assign accept = pc_valid & bus.enable & !bus.redirect_valid;
   assign push   = accept & bus.call_valid;
   assign pop    = accept & bus.ret_valid;
   always_comb begin
      sel  = !pc_valid                     ? SEL_HOLD :
             bus.redirect_valid            ? SEL_REDIRECT :
             bus.enable && pop && !ras_empty ? SEL_RAS :
             bus.enable                    ? SEL_SEQ : SEL_HOLD;
      pc_d = sel == SEL_REDIRECT ? bus.redirect_addr :
             sel == SEL_RAS      ? ras_top :
             sel == SEL_SEQ      ? pc_nxt : pc_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pc_q     <= RESET_VEC;
         pc_valid <= 1'b0;
         ret_miss <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         pc_valid <= 1'b1;
         ret_miss <= pop & ras_empty;
      end
   ras_stack #(.RAS_DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_nxt),
      .top_data  (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );
   assign bus.pc_out       = pc_q;
   assign bus.pc_nxt       = pc_nxt;
   assign bus.pc_valid     = pc_valid;
   assign bus.ras_empty    = ras_empty;
   assign bus.ras_full     = ras_full;
   assign bus.ras_overflow = ras_overflow;
   assign bus.ret_miss     = ret_miss;
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed and randomized checks of pc_gen_ras against a queue-based model
module tb_pc_gen_ras;
   localparam int DEPTH = 4;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   logic [15:0] m_pc;
   logic        m_valid;
   logic        m_ovf;
   logic        m_miss;
   logic [15:0] ras [$];
   pc_gen_ras_if #(.ADDR_W(16)) bus ();
   pc_gen_ras #(.ADDR_W(16), .INSTR_BYTES(2), .RESET_VEC(16'h0000), .RAS_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   task automatic drive(input logic en, input logic rd, input logic [15:0] addr,
                        input logic call, input logic ret);
      bus.enable         = en;
      bus.redirect_valid = rd;
      bus.redirect_addr  = addr;
      bus.call_valid     = call;
      bus.ret_valid      = ret;
   endtask
   // reference: the RAS is a plain queue of return addresses, newest at the back
   task automatic tick();
      logic [15:0] nxt;
      logic [15:0] npc;
      logic        nmiss;
      nxt   = m_pc + 16'd2;
      npc   = m_pc;
      nmiss = 1'b0;
      if (m_valid) begin
         if (bus.redirect_valid) npc = bus.redirect_addr;
         else if (bus.enable) begin
            npc = nxt;
            if (bus.ret_valid) begin
               if (ras.size() != 0) npc = ras.pop_back();
               else nmiss = 1'b1;
            end
            if (bus.call_valid) begin
               ras.push_back(nxt);
               if (ras.size() > DEPTH) begin
                  void'(ras.pop_front());
                  m_ovf = 1'b1;
               end
            end
         end
      end
      m_pc    = npc;
      m_miss  = nmiss;
      m_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask
   task automatic apply_reset();
      reset_n = 1'b0;
      drive(0, 0, 16'h0, 0, 0);
      m_pc    = 16'h0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_miss  = 1'b0;
      ras.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask
   task automatic goto(input logic [15:0] a);
      drive(0, 1, a, 0, 0);
      tick();
   endtask
   task automatic test_reset();
      apply_reset();
      drive(1, 0, 16'h0, 0, 0);
      tick();
      checks++;
      if ({bus.pc_valid, bus.pc_out} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL reset_first_fetch got valid=%b pc=%h exp valid=1 pc=0000", bus.pc_valid, bus.pc_out);
      end
      tick();
      checks++;
      if (bus.pc_out !== 16'h0002) begin
         errors++;
         $display("FAIL reset_seq got %h exp 0002", bus.pc_out);
      end
      drive(1, 0, 16'h0, 1, 0);
      tick();
      tick();
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.pc_out, bus.pc_valid, bus.ras_empty, bus.ras_overflow, bus.ret_miss} !== {16'h0000, 4'b0100}) begin
         errors++;
         $display("FAIL reset_async got pc=%h valid=%b empty=%b ovf=%b miss=%b exp pc=0000 valid=0 empty=1 ovf=0 miss=0",
                  bus.pc_out, bus.pc_valid, bus.ras_empty, bus.ras_overflow, bus.ret_miss);
      end
      apply_reset();
   endtask
   task automatic test_wrap();
      logic [15:0] exp [3];
      exp = '{16'hFFFE, 16'h0000, 16'h0002};
      apply_reset();
      tick();
      goto(16'hFFFC);
      drive(1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.pc_out !== exp[i]) begin
            errors++;
            $display("FAIL wrap_%0d got %h exp %h", i, bus.pc_out, exp[i]);
         end
         if (i == 0) begin
            checks++;
            if (bus.pc_nxt !== 16'h0000) begin
               errors++;
               $display("FAIL wrap_pc_nxt got %h exp 0000", bus.pc_nxt);
            end
         end
      end
   endtask
   task automatic test_stall_redirect();
      apply_reset();
      tick();
      goto(16'h0010);
      drive(0, 0, 16'h0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.pc_out, bus.ras_empty, bus.ret_miss} !== {16'h0010, 2'b10}) begin
            errors++;
            $display("FAIL stall_%0d got pc=%h empty=%b miss=%b exp pc=0010 empty=1 miss=0",
                     i, bus.pc_out, bus.ras_empty, bus.ret_miss);
         end
      end
      drive(0, 1, 16'h0400, 0, 0);
      tick();
      checks++;
      if (bus.pc_out !== 16'h0400) begin
         errors++;
         $display("FAIL stall_redirect got %h exp 0400", bus.pc_out);
      end
   endtask
   task automatic test_call_ret();
      apply_reset();
      tick();
      goto(16'h0020);
      drive(1, 0, 16'h0, 1, 0);
      tick();
      goto(16'h0100);
      drive(1, 0, 16'h0, 0, 0);
      repeat (4) tick();
      checks++;
      if ({bus.pc_out, bus.ras_empty} !== {16'h0108, 1'b0}) begin
         errors++;
         $display("FAIL call_ret_pre got pc=%h empty=%b exp pc=0108 empty=0", bus.pc_out, bus.ras_empty);
      end
      drive(1, 0, 16'h0, 0, 1);
      tick();
      checks++;
      if ({bus.pc_out, bus.ras_empty, bus.ret_miss} !== {16'h0022, 2'b10}) begin
         errors++;
         $display("FAIL call_ret got pc=%h empty=%b miss=%b exp pc=0022 empty=1 miss=0",
                  bus.pc_out, bus.ras_empty, bus.ret_miss);
      end
   endtask
   task automatic test_overflow();
      logic [15:0] exp [4];
      exp = '{16'h0052, 16'h0042, 16'h0032, 16'h0022};
      apply_reset();
      tick();
      for (int i = 1; i <= 5; i++) begin
         goto(16'(i * 16));
         drive(1, 0, 16'h0, 1, 0);
         tick();
         if (i == 4) begin
            checks++;
            if ({bus.ras_full, bus.ras_overflow} !== 2'b10) begin
               errors++;
               $display("FAIL ovf_full4 got full=%b ovf=%b exp full=1 ovf=0", bus.ras_full, bus.ras_overflow);
            end
         end
      end
      checks++;
      if ({bus.ras_full, bus.ras_overflow} !== 2'b11) begin
         errors++;
         $display("FAIL ovf_flag got full=%b ovf=%b exp full=1 ovf=1", bus.ras_full, bus.ras_overflow);
      end
      drive(1, 0, 16'h0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (bus.pc_out !== exp[i]) begin
            errors++;
            $display("FAIL ovf_ret_%0d got %h exp %h", i, bus.pc_out, exp[i]);
         end
      end
      tick();
      checks++;
      if ({bus.pc_out, bus.ret_miss, bus.ras_empty, bus.ras_overflow} !== {16'h0024, 3'b111}) begin
         errors++;
         $display("FAIL ovf_miss got pc=%h miss=%b empty=%b ovf=%b exp pc=0024 miss=1 empty=1 ovf=1",
                  bus.pc_out, bus.ret_miss, bus.ras_empty, bus.ras_overflow);
      end
      drive(0, 0, 16'h0, 0, 0);
      tick();
      checks++;
      if ({bus.pc_out, bus.ret_miss} !== {16'h0024, 1'b0}) begin
         errors++;
         $display("FAIL ovf_miss_pulse got pc=%h miss=%b exp pc=0024 miss=0", bus.pc_out, bus.ret_miss);
      end
   endtask
   task automatic test_same_cycle();
      apply_reset();
      tick();
      goto(16'h0200);
      drive(1, 0, 16'h0, 1, 0);
      tick();
      goto(16'h0060);
      drive(1, 0, 16'h0, 1, 1);
      tick();
      checks++;
      if ({bus.pc_out, bus.ras_empty, bus.ras_full, bus.ret_miss} !== {16'h0202, 3'b000}) begin
         errors++;
         $display("FAIL same_cycle got pc=%h empty=%b full=%b miss=%b exp pc=0202 empty=0 full=0 miss=0",
                  bus.pc_out, bus.ras_empty, bus.ras_full, bus.ret_miss);
      end
      drive(1, 0, 16'h0, 0, 1);
      tick();
      checks++;
      if ({bus.pc_out, bus.ras_empty} !== {16'h0062, 1'b1}) begin
         errors++;
         $display("FAIL same_cycle_top got pc=%h empty=%b exp pc=0062 empty=1", bus.pc_out, bus.ras_empty);
      end
      drive(1, 0, 16'h0, 1, 1);
      tick();
      checks++;
      if ({bus.pc_out, bus.ras_empty, bus.ret_miss} !== {16'h0064, 2'b01}) begin
         errors++;
         $display("FAIL same_cycle_empty got pc=%h empty=%b miss=%b exp pc=0064 empty=0 miss=1",
                  bus.pc_out, bus.ras_empty, bus.ret_miss);
      end
      drive(1, 0, 16'h0, 0, 1);
      tick();
      checks++;
      if ({bus.pc_out, bus.ras_empty, bus.ret_miss} !== {16'h0064, 2'b10}) begin
         errors++;
         $display("FAIL same_cycle_pop got pc=%h empty=%b miss=%b exp pc=0064 empty=1 miss=0",
                  bus.pc_out, bus.ras_empty, bus.ret_miss);
      end
   endtask
   task automatic test_random();
      logic [15:0] a;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         a = 16'($urandom) & 16'hFFFE;
         if (i == 300) apply_reset();
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, a,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         tick();
         checks++;
         if ({bus.pc_out, bus.pc_nxt, bus.pc_valid, bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ret_miss} !==
             {m_pc, 16'(m_pc + 16'd2), m_valid, ras.size() == 0, ras.size() == DEPTH, m_ovf, m_miss}) begin
            errors++;
            $display("FAIL random_%0d got pc=%h nxt=%h v=%b e=%b f=%b o=%b m=%b exp pc=%h nxt=%h v=%b e=%b f=%b o=%b m=%b",
                     i, bus.pc_out, bus.pc_nxt, bus.pc_valid, bus.ras_empty, bus.ras_full, bus.ras_overflow,
                     bus.ret_miss, m_pc, 16'(m_pc + 16'd2), m_valid, ras.size() == 0, ras.size() == DEPTH,
                     m_ovf, m_miss);
         end
      end
   endtask
   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      drive(0, 0, 16'h0, 0, 0);
      #1;
      checks++;
      if ({bus.pc_out, bus.pc_valid, bus.ras_empty, bus.ras_full} !== {16'h0000, 3'b010}) begin
         errors++;
         $display("FAIL reset_init got pc=%h valid=%b empty=%b full=%b exp pc=0000 valid=0 empty=1 full=0",
                  bus.pc_out, bus.pc_valid, bus.ras_empty, bus.ras_full);
      end
      test_reset();
      test_wrap();
      test_stall_redirect();
      test_call_ret();
      test_overflow();
      test_same_cycle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
